jk_seq_ctrl: RTL



---
 rtl/jk_seq_ctrl.sv | 131 +++++++++++++
 1 files changed

// File: rtl/jk_seq_ctrl.sv
// Stepped JK flip-flop bank controller: up/down/Gray/load commands over valid/ready.
// Optional stall input enabled by defining JK_SEQ_PAUSE_EN.
module jk_seq_ctrl #(
  parameter int WIDTH  = 3,
  parameter int STEP_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_mode,
  input  logic [STEP_W-1:0] cmd_steps,
  input  logic [WIDTH-1:0]  cmd_data,
`ifdef JK_SEQ_PAUSE_EN
  input  logic              pause,
`endif
  output logic [WIDTH-1:0]  j,
  output logic [WIDTH-1:0]  k,
  output logic [WIDTH-1:0]  q,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam logic [1:0] M_UP   = 2'b00;
  localparam logic [1:0] M_DOWN = 2'b01;
  localparam logic [1:0] M_GRAY = 2'b10;
  localparam logic [1:0] M_LOAD = 2'b11;

  state_t            state, state_nx;
  logic [1:0]        mode;
  logic [WIDTH-1:0]  data;
  logic [STEP_W-1:0] remaining;
  logic [WIDTH-1:0]  nxt;
  logic              stall;
  logic              step;
  logic              accept;

  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

`ifdef JK_SEQ_PAUSE_EN
  assign stall = pause;
`else
  assign stall = 1'b0;
`endif

  assign accept = (state == IDLE) && cmd_valid;
  assign step   = (state == RUN) && !stall;

  always_comb begin
    nxt = q;
    unique case (mode)
      M_UP:   nxt = q + WIDTH'(1);
      M_DOWN: nxt = q - WIDTH'(1);
      M_GRAY: nxt = bin2gray(gray2bin(q) + WIDTH'(1));
      M_LOAD: nxt = data;
      default: nxt = q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      q         <= '0;
      mode      <= M_UP;
      data      <= '0;
      remaining <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        mode      <= cmd_mode;
        data      <= cmd_data;
        remaining <= (cmd_mode == M_LOAD) ? STEP_W'(1) : cmd_steps;
      end else if (step) begin
        // JK characteristic equation; lands exactly on nxt
        q         <= (j & ~q) | (~k & q);
        remaining <= remaining - STEP_W'(1);
      end
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (cmd_valid) begin
          if (cmd_mode != M_LOAD && cmd_steps == '0) state_nx = FIN;
          else                                       state_nx = RUN;
        end
      end
      RUN:  if (step && remaining == STEP_W'(1)) state_nx = FIN;
      FIN:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    j         = '0;
    k         = '0;
    unique case (state)
      IDLE: cmd_ready = 1'b1;
      RUN: begin
        busy = 1'b1;
        if (!stall) begin
          j = ~q & nxt;
          k = q & ~nxt;
        end
      end
      FIN:  done = 1'b1;
      default: ;
    endcase
  end

endmodule
